// File: rtl/pmod_mic_pkg.sv
// Shared constants and FSM encoding for the PmodMIC sampler.
package pmod_mic_pkg;

  localparam int FRAME_LEN = 16;
  localparam int DATA_W    = 12;
  localparam int LEAD_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    QUIET = 2'd2,
    WAIT  = 2'd3
  } state_t;

  // The ADC sends LEAD_W leading bits before the sample; they should all be zero.
  function automatic logic lead_nonzero(input logic [FRAME_LEN-1:0] word);
    return |word[FRAME_LEN-1 -: LEAD_W];
  endfunction

endpackage

// File: rtl/pmod_mic_period_timer.sv
// Sample-period counter: counts 0..SAMPLE_DIV-1 and wraps, held at 0 while hold is high.
module pmod_mic_period_timer #(
  parameter int SAMPLE_DIV = 1250
) (
  input  logic clk_sclk,
  input  logic rst_n,
  input  logic hold,
  output logic tick
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (hold) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_sclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/pmod_mic_sampler.sv
// PmodMIC periodic sampler: frame FSM, serial shift-in, one-entry output buffer with overrun stats.
// Optional leading-bit check enabled by defining MIC_FRAME_CHECK_EN (drives frame_err).
module pmod_mic_sampler
  import pmod_mic_pkg::*;
#(
  parameter int SAMPLE_DIV = 1250,
  parameter int QUIET_CYC  = 2,
  parameter int CNT_W      = 8
) (
  input  logic              clk_sclk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mic_sdata,
  output logic              mic_ncs,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              overrun,
  output logic [CNT_W-1:0]  overrun_cnt,
  input  logic              clr_stat,
  output logic              frame_err
);

  localparam int CYC_MAX = (QUIET_CYC > FRAME_LEN) ? QUIET_CYC : FRAME_LEN;
  localparam int CYC_W   = $clog2(CYC_MAX);

  if ((SAMPLE_DIV < FRAME_LEN + QUIET_CYC) || (QUIET_CYC < 1)) begin : g_param_check
    $error("pmod_mic_sampler: SAMPLE_DIV must be >= FRAME_LEN+QUIET_CYC and QUIET_CYC >= 1");
  end

  state_t               state_q, state_d;
  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic [FRAME_LEN-1:0] shift_q, shift_d, shift_word;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ncs_q, ncs_d;
  logic                 busy_q, busy_d;
  logic                 ovr_q, ovr_d;
  logic [CNT_W-1:0]     ovr_cnt_q, ovr_cnt_d;
  logic                 wr_en, drain, ovr_event, tick;
  logic                 unused_msb;

  pmod_mic_period_timer #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_timer (
    .clk_sclk(clk_sclk),
    .rst_n   (rst_n),
    .hold    (state_q == IDLE),
    .tick    (tick)
  );

  // The oldest bit falls off the end of the register on every shift.
  assign unused_msb = shift_q[FRAME_LEN-1];
  assign shift_word = {shift_q[FRAME_LEN-2:0], mic_sdata};

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    shift_d = shift_q;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cyc_d = '0;
        if (en) state_d = SHIFT;
      end
      SHIFT: begin
        shift_d = shift_word;
        if (cyc_q == CYC_W'(FRAME_LEN - 1)) begin
          wr_en   = 1'b1;
          cyc_d   = '0;
          state_d = QUIET;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      QUIET: begin
        if (!en) begin
          cyc_d   = '0;
          state_d = IDLE;
        end else if (cyc_q == CYC_W'(QUIET_CYC - 1)) begin
          // With the tightest SAMPLE_DIV the period tick lands on the last quiet cycle.
          cyc_d   = '0;
          state_d = tick ? SHIFT : WAIT;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      WAIT: begin
        if (!en)       state_d = IDLE;
        else if (tick) state_d = SHIFT;
      end
      default: state_d = IDLE;
    endcase
    ncs_d  = (state_d != SHIFT);
    busy_d = (state_d == SHIFT) || (state_d == QUIET);
  end

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    ovr_cnt_d = ovr_cnt_q;
    drain     = valid_q && sample_ready;
    ovr_event = wr_en && valid_q && !sample_ready;
    if (wr_en && !ovr_event) begin
      data_d  = shift_word[DATA_W-1:0];
      valid_d = 1'b1;
    end else if (drain) begin
      valid_d = 1'b0;
    end
    // A drop in the same cycle as clr_stat is counted as the first event after the clear.
    if (ovr_event) begin
      ovr_d = 1'b1;
      if (clr_stat)                ovr_cnt_d = CNT_W'(1);
      else if (ovr_cnt_q != '1)    ovr_cnt_d = ovr_cnt_q + CNT_W'(1);
    end else if (clr_stat) begin
      ovr_d     = 1'b0;
      ovr_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ncs_q     <= 1'b1;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
      ovr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ncs_q     <= ncs_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

`ifdef MIC_FRAME_CHECK_EN
  logic frame_err_q, frame_err_d;

  always_comb begin
    frame_err_d = frame_err_q;
    if (wr_en && lead_nonzero(shift_word)) frame_err_d = 1'b1;
    else if (clr_stat)                     frame_err_d = 1'b0;
  end

  always_ff @(posedge clk_sclk or negedge rst_n) begin
    if (!rst_n) frame_err_q <= 1'b0;
    else        frame_err_q <= frame_err_d;
  end

  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

  assign mic_ncs      = ncs_q;
  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign overrun      = ovr_q;
  assign overrun_cnt  = ovr_cnt_q;

endmodule

// File: tb/tb_pmod_mic_sampler.sv
// Scoreboard bench for pmod_mic_sampler with a behavioural PmodMIC ADC model.
module tb_pmod_mic_sampler;

  localparam int DIV = 40;

  logic        clk_sclk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        mic_sdata;
  logic        mic_ncs;
  logic [11:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        busy;
  logic        overrun;
  logic [7:0]  overrun_cnt;
  logic        clr_stat;
  logic        frame_err;

  pmod_mic_sampler #(
    .SAMPLE_DIV(DIV),
    .QUIET_CYC (2),
    .CNT_W     (8)
  ) dut (
    .clk_sclk    (clk_sclk),
    .rst_n       (rst_n),
    .en          (en),
    .mic_sdata   (mic_sdata),
    .mic_ncs     (mic_ncs),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .busy        (busy),
    .overrun     (overrun),
    .overrun_cnt (overrun_cnt),
    .clr_stat    (clr_stat),
    .frame_err   (frame_err)
  );

  always #5 clk_sclk = ~clk_sclk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [11:0] exp_q[$];
  logic [15:0] adc_q[$];

  // Monitor state
  int   frame_cnt = 0, fall_cnt = 0, xfer_cnt = 0;
  int   lowcnt = 0, vlen = 0, last_fall = 0;
  bit   have_fall = 0, prev_ncs = 1, prev_valid = 0;
  bit   chk_period = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk_sclk) cyc++;

  // ADC model: drives the next bit MSB first on the falling edge while chip select is low.
  int          bit_idx = 0;
  logic [15:0] adc_word = '0;
  always @(negedge clk_sclk) begin
    if (!mic_ncs) begin
      if (bit_idx == 0) adc_word = (adc_q.size() != 0) ? adc_q.pop_front() : 16'h0000;
      mic_sdata = adc_word[15 - bit_idx];
      bit_idx++;
    end else begin
      bit_idx = 0;
    end
  end

  always @(negedge clk_sclk) begin
    logic [11:0] e;
    if (!chk_period) have_fall = 0;
    if (!rst_n) begin
      lowcnt = 0; vlen = 0; prev_ncs = 1; prev_valid = 0;
    end else begin
      if (!mic_ncs) begin
        if (prev_ncs) begin
          fall_cnt++;
          if (chk_period && have_fall) check_eq("ncs_period", cyc - last_fall, DIV);
          have_fall = 1;
          last_fall = cyc;
        end
        lowcnt++;
      end else if (lowcnt != 0) begin
        check_eq("ncs_low_len", lowcnt, 16);
        frame_cnt++;
        lowcnt = 0;
      end
      if (sample_valid && !prev_valid) check_eq("valid_latency", cyc - last_fall, 16);
      if (sample_valid) vlen++;
      else begin
        if (vlen != 0 && chk_period) check_eq("valid_len", vlen, 1);
        vlen = 0;
      end
      if (sample_valid && sample_ready) begin
        if (exp_q.size() == 0) check_eq("sb_underflow", 1, 0);
        else begin
          e = exp_q.pop_front();
          check_eq("sample", sample_data, e);
          xfer_cnt++;
        end
      end
      prev_ncs = mic_ncs;
      prev_valid = sample_valid;
    end
  end

  task automatic step();
    @(posedge clk_sclk);
    #2;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int target = frame_cnt + n;
    int k = 0;
    while (frame_cnt < target && k < budget) begin step(); k++; end
    if (frame_cnt < target) check_eq("timeout_frames", 0, 1);
  endtask

  task automatic wait_xfers(input int n, input int budget);
    int target = xfer_cnt + n;
    int k = 0;
    while (xfer_cnt < target && k < budget) begin step(); k++; end
    if (xfer_cnt < target) check_eq("timeout_xfers", 0, 1);
  endtask

  task automatic wait_ncs_low(input int budget);
    int k = 0;
    while (mic_ncs && k < budget) begin step(); k++; end
    if (mic_ncs) check_eq("timeout_ncs_low", 0, 1);
  endtask

  task automatic push(input logic [15:0] word, input bit deliver);
    adc_q.push_back(word);
    if (deliver) exp_q.push_back(word[11:0]);
  endtask

  initial begin
    int snap;
    logic exp_ferr;
`ifdef MIC_FRAME_CHECK_EN
    exp_ferr = 1'b1;
`else
    exp_ferr = 1'b0;
`endif
    rst_n = 0; en = 0; sample_ready = 1; clr_stat = 0; mic_sdata = 0;
    repeat (3) step();
    check_eq("rst_ncs", mic_ncs, 1);
    check_eq("rst_valid", sample_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_data", sample_data, 0);
    check_eq("rst_ovr_cnt", overrun_cnt, 0);
    rst_n = 1;
    repeat (3) step();
    check_eq("idle_ncs", mic_ncs, 1);

    // Periodic capture with a ready consumer
    chk_period = 1;
    repeat (3) push(16'h0ABC, 1);
    en = 1;
    wait_frames(3, 300);
    en = 0; chk_period = 0;
    repeat (3) step();
    check_eq("p1_data", sample_data, 12'hABC);
    check_eq("p1_drained", exp_q.size(), 0);
    check_eq("p1_busy", busy, 0);

    // Overrun across three frames, then a drop coinciding with clr_stat
    sample_ready = 0;
    push(16'h0111, 1); push(16'h0222, 0); push(16'h0333, 0); push(16'h0444, 0);
    en = 1;
    wait_frames(3, 300);
    check_eq("ovr_data", sample_data, 12'h111);
    check_eq("ovr_valid", sample_valid, 1);
    check_eq("ovr_flag", overrun, 1);
    check_eq("ovr_cnt", overrun_cnt, 2);
    wait_ncs_low(100);
    repeat (15) @(posedge clk_sclk);
    #1 clr_stat = 1;
    @(posedge clk_sclk);
    #1 clr_stat = 0; en = 0;
    #1;
    check_eq("ovr_clr_race_flag", overrun, 1);
    check_eq("ovr_clr_race_cnt", overrun_cnt, 1);
    check_eq("ovr_clr_race_data", sample_data, 12'h111);
    repeat (3) step();
    sample_ready = 1;
    wait_xfers(1, 20);
    clr_stat = 1; step(); clr_stat = 0;
    check_eq("clr_flag", overrun, 0);
    check_eq("clr_cnt", overrun_cnt, 0);

    // Drain and write on the same edge
    sample_ready = 0;
    push(16'h0555, 1); push(16'h0666, 1);
    en = 1;
    wait_frames(1, 100);
    wait_ncs_low(100);
    repeat (15) @(posedge clk_sclk);
    #1 sample_ready = 1;
    @(posedge clk_sclk);
    #1 sample_ready = 0; en = 0;
    #1;
    check_eq("dw_ovr", overrun, 0);
    check_eq("dw_data", sample_data, 12'h666);
    check_eq("dw_valid", sample_valid, 1);
    sample_ready = 1;
    wait_xfers(1, 20);

    // en dropped in the 5th SHIFT cycle
    push(16'h0777, 1);
    en = 1;
    wait_ncs_low(100);
    repeat (4) @(posedge clk_sclk);
    #1 en = 0;
    wait_frames(1, 100);
    snap = fall_cnt;
    repeat (60) step();
    check_eq("stop_no_fall", fall_cnt, snap);
    check_eq("stop_busy", busy, 0);
    check_eq("stop_ncs", mic_ncs, 1);
    check_eq("stop_delivered", exp_q.size(), 0);

    // Asynchronous reset in the 8th SHIFT cycle
    push(16'h0888, 0); push(16'h0999, 1);
    en = 1;
    wait_ncs_low(100);
    repeat (7) @(posedge clk_sclk);
    #1 rst_n = 0;
    #1;
    check_eq("arst_ncs", mic_ncs, 1);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_valid", sample_valid, 0);
    check_eq("arst_data", sample_data, 0);
    check_eq("arst_ovr", overrun, 0);
    check_eq("arst_ferr", frame_err, 0);
    step(); step();
    rst_n = 1;
    wait_frames(1, 100);
    en = 0;
    repeat (3) step();
    check_eq("arst_resume_data", sample_data, 12'h999);

    // Non-zero leading bits
    push(16'h8ABC, 1);
    en = 1;
    wait_frames(1, 100);
    en = 0;
    repeat (3) step();
    check_eq("ferr_data", sample_data, 12'hABC);
    check_eq("ferr_flag", frame_err, exp_ferr);
    clr_stat = 1; step(); clr_stat = 0;
    check_eq("ferr_clr", frame_err, 0);
    check_eq("final_sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
